// File: rtl/ultrasonic_ranger_if.sv
`default_nettype none
// ============================================================================
//  Module      : ultrasonic_ranger_if
//  Description : Bundle of the sensor-side and result-side signals of the
//                ultrasonic ranger. The ranger itself connects through the
//                slave modport. Whatever drives en/echo and consumes the
//                result connects through the master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ultrasonic_ranger_if;

    logic        en;           // 1 = free-run measurements
    logic        echo;         // raw sensor echo pin (asynchronous)
    logic        trig;         // sensor trigger pin
    logic [31:0] echo_width;   // last result in clk cycles
    logic        width_valid;  // 1-cycle pulse: real measurement published
    logic        timeout;      // 1-cycle pulse: timeout value published

    // Controlling / consuming side
    modport master (
        output en,
        output echo,
        input  trig,
        input  echo_width,
        input  width_valid,
        input  timeout
    );

    // Ranger side
    modport slave (
        input  en,
        input  echo,
        output trig,
        output echo_width,
        output width_valid,
        output timeout
    );

endinterface : ultrasonic_ranger_if
`default_nettype wire

// File: rtl/ultrasonic_ranger.sv
`default_nettype none
// ============================================================================
//  Module      : ultrasonic_ranger
//  Description : HC-SR04-style ultrasonic sensor driver. Issues a periodic
//                trigger pulse, times the returned echo pulse in clk cycles
//                and publishes the result (or the timeout value) on
//                echo_width with a one-cycle qualifier pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module ultrasonic_ranger #(
    parameter int unsigned CLK_FREQ_HZ = 12_000_000,
    parameter int unsigned TRIG_US     = 10,
    parameter int unsigned TIMEOUT_US  = 38_000,
    parameter int unsigned PERIOD_MS   = 60
) (
    input  logic                clk,
    input  logic                reset_n,
    ultrasonic_ranger_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Derived tick counts
    // ------------------------------------------------------------------------
    localparam int unsigned c_TICKS_PER_US = CLK_FREQ_HZ / 1_000_000;
    localparam logic [31:0] c_TRIG_TICKS    = 32'(c_TICKS_PER_US * TRIG_US);
    localparam logic [31:0] c_TIMEOUT_TICKS = 32'(c_TICKS_PER_US * TIMEOUT_US);
    localparam logic [31:0] c_PERIOD_TICKS  = 32'(c_TICKS_PER_US * 1000 * PERIOD_MS);

    // Refuse to elaborate with an inconsistent timing set: the period must
    // contain the whole timeout window, which must contain the trigger pulse.
    generate
        if ((CLK_FREQ_HZ % 1_000_000 != 0) ||
            !(c_PERIOD_TICKS > c_TIMEOUT_TICKS) ||
            !(c_TIMEOUT_TICKS > c_TRIG_TICKS) ||
            !(c_TRIG_TICKS >= 32'd1)) begin : g_bad_params
            $error("ultrasonic_ranger: need PERIOD_TICKS > TIMEOUT_TICKS > TRIG_TICKS >= 1 and CLK_FREQ_HZ a multiple of 1 MHz");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_HOLDOFF   = 2'd0;
    localparam logic [1:0] S_TRIG      = 2'd1;
    localparam logic [1:0] S_WAIT_RISE = 2'd2;
    localparam logic [1:0] S_MEASURE   = 2'd3;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic        r_echo_meta;     // first synchronizer stage
    logic        r_echo_s;        // synchronized echo
    logic        r_echo_d;        // echo_s delayed one cycle, for edge detection
    logic [1:0]  r_state;
    logic [31:0] r_cyc;           // cycles since the current trigger started
    logic [31:0] r_width_cnt;     // echo high time accumulated so far
    logic [31:0] r_echo_width;
    logic        r_width_valid;
    logic        r_timeout;
    logic        r_trig;

    // ------------------------------------------------------------------------
    // Combinational next-state values
    // ------------------------------------------------------------------------
    logic        w_rise;
    logic        w_fall;
    logic        w_cyc_sat;
    logic        w_cyc_timeout;
    logic [1:0]  w_state_nxt;
    logic [31:0] w_cyc_nxt;
    logic [31:0] w_width_cnt_nxt;
    logic [31:0] w_echo_width_nxt;
    logic        w_width_valid_nxt;
    logic        w_timeout_nxt;
    logic        w_trig_nxt;

    assign w_rise        =  r_echo_s & ~r_echo_d;
    assign w_fall        = ~r_echo_s &  r_echo_d;
    assign w_cyc_sat     = (r_cyc == c_PERIOD_TICKS - 32'd1);
    assign w_cyc_timeout = (r_cyc == c_TIMEOUT_TICKS - 32'd1);

    // Bring the asynchronous echo pin into the clk domain and keep a delayed copy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_echo_meta <= 1'b0;
            r_echo_s    <= 1'b0;
            r_echo_d    <= 1'b0;
        end else begin
            r_echo_meta <= bus.echo;
            r_echo_s    <= r_echo_meta;
            r_echo_d    <= r_echo_s;
        end
    end

    // Measurement sequencing: trigger, wait for a fresh rise, time the pulse
    always_comb begin
        w_state_nxt       = r_state;
        w_cyc_nxt         = w_cyc_sat ? r_cyc : (r_cyc + 32'd1);
        w_width_cnt_nxt   = r_width_cnt;
        w_echo_width_nxt  = r_echo_width;
        w_width_valid_nxt = 1'b0;
        w_timeout_nxt     = 1'b0;

        case (r_state)
            S_HOLDOFF: begin
                // en only matters here; a running measurement always completes
                if (w_cyc_sat && bus.en) begin
                    w_state_nxt = S_TRIG;
                    w_cyc_nxt   = 32'd0;
                end
            end

            S_TRIG: begin
                if (r_cyc == c_TRIG_TICKS - 32'd1) begin
                    w_state_nxt = S_WAIT_RISE;
                end
            end

            S_WAIT_RISE: begin
                // An echo already high on entry produces no rise and is ignored
                if (w_cyc_timeout) begin
                    w_echo_width_nxt = c_TIMEOUT_TICKS;
                    w_timeout_nxt    = 1'b1;
                    w_state_nxt      = S_HOLDOFF;
                end else if (w_rise) begin
                    w_width_cnt_nxt = 32'd1;
                    w_state_nxt     = S_MEASURE;
                end
            end

            S_MEASURE: begin
                // A fall on the timeout cycle still counts as a real result
                if (w_fall) begin
                    w_echo_width_nxt  = r_width_cnt;
                    w_width_valid_nxt = 1'b1;
                    w_state_nxt       = S_HOLDOFF;
                end else if (w_cyc_timeout) begin
                    w_echo_width_nxt = c_TIMEOUT_TICKS;
                    w_timeout_nxt    = 1'b1;
                    w_state_nxt      = S_HOLDOFF;
                end else if (r_echo_s) begin
                    w_width_cnt_nxt = r_width_cnt + 32'd1;
                end
            end

            default: begin
                w_state_nxt = S_HOLDOFF;
            end
        endcase

        // trig is a flop copy of "in S_TRIG", so it follows the state exactly
        w_trig_nxt = (w_state_nxt == S_TRIG);
    end

    // State, counters and published outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_HOLDOFF;
            r_cyc         <= 32'd0;
            r_width_cnt   <= 32'd0;
            r_echo_width  <= 32'd0;
            r_width_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_trig        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cyc         <= w_cyc_nxt;
            r_width_cnt   <= w_width_cnt_nxt;
            r_echo_width  <= w_echo_width_nxt;
            r_width_valid <= w_width_valid_nxt;
            r_timeout     <= w_timeout_nxt;
            r_trig        <= w_trig_nxt;
        end
    end

    assign bus.trig        = r_trig;
    assign bus.echo_width  = r_echo_width;
    assign bus.width_valid = r_width_valid;
    assign bus.timeout     = r_timeout;

endmodule : ultrasonic_ranger
`default_nettype wire

// File: tb/tb_ultrasonic_ranger.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ultrasonic_ranger
//  Description : Self-checking bench for ultrasonic_ranger. 1 tick = 1 us.
//                Timeout and period are scaled down tenfold (3.8 ms / 6 ms)
//                so the whole run stays short; trigger stays 10 us.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ultrasonic_ranger;

    localparam int c_P    = 6000;   // PERIOD_TICKS
    localparam int c_TO   = 3800;   // TIMEOUT_TICKS
    localparam int c_TRIG = 10;     // TRIG_TICKS
    localparam int c_NVEC = 8;

    // One measurement scenario: raw echo timing relative to the trig rise
    // (echo is driven high for len cycles after sample point 'start'), and
    // the expected result: offset of the qualifier pulse from trig rise.
    typedef struct {
        int start;
        int len;
        bit stuck;
        int exp_off;
        int exp_width;
        bit exp_valid;
        bit exp_to;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    ultrasonic_ranger_if bus ();

    ultrasonic_ranger #(
        .CLK_FREQ_HZ (1_000_000),
        .TRIG_US     (10),
        .TIMEOUT_US  (3_800),
        .PERIOD_MS   (6)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_trig(output bit ok);
        int n;
        n = 0;
        while (bus.trig !== 1'b1 && n < c_P + 100) begin
            step();
            n++;
        end
        ok = (bus.trig === 1'b1);
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL trig_wait: trig=%0b after %0d cycles, expected 1", bus.trig, n);
        end
    endtask

    function automatic bit echo_at(input vec_t v, input int j);
        if (v.stuck) return (j < 4500);
        return (j >= v.start) && (j < v.start + v.len);
    endfunction

    initial begin
        vec_t vecs [c_NVEC];
        bit   ok;
        bit   aborted;
        int   prev_rise;
        int   first_off;
        int   width_at;
        int   nv, nt, ntrig;

        // start len stuck | off width valid timeout
        vecs[0] = '{500, 1480, 1'b0, 1983, 1480, 1'b1, 1'b0};  // normal echo
        vecs[1] = '{0,   0,    1'b0, c_TO, c_TO, 1'b0, 1'b1};  // no echo at all
        vecs[2] = '{0,   0,    1'b1, c_TO, c_TO, 1'b0, 1'b1};  // echo stuck high
        vecs[3] = '{500, 3297, 1'b0, c_TO, 3297, 1'b1, 1'b0};  // fall on timeout cycle
        vecs[4] = '{500, 3296, 1'b0, 3799, 3296, 1'b1, 1'b0};  // fall one cycle early
        vecs[5] = '{500, 3298, 1'b0, c_TO, c_TO, 1'b0, 1'b1};  // fall one cycle late
        vecs[6] = '{8,   1,    1'b0, 12,   1,    1'b1, 1'b0};  // earliest accepted rise
        vecs[7] = '{7,   5,    1'b0, c_TO, c_TO, 1'b0, 1'b1};  // rise during trig: ignored

        aborted  = 1'b0;
        bus.en   = 1'b1;
        bus.echo = 1'b0;

        repeat (3) step();
        check("reset_trig",        bus.trig,        0);
        check("reset_echo_width",  bus.echo_width,  0);
        check("reset_width_valid", bus.width_valid, 0);
        check("reset_timeout",     bus.timeout,     0);

        reset_n   = 1'b1;
        prev_rise = edge_cnt;

        for (int i = 0; i < c_NVEC; i++) begin
            wait_trig(ok);
            if (!ok) begin
                aborted = 1'b1;
                break;
            end
            check($sformatf("v%0d_trig_period", i), edge_cnt - prev_rise, c_P);
            prev_rise = edge_cnt;
            first_off = -1;
            width_at  = 0;
            nv = 0;
            nt = 0;
            ntrig = 0;
            for (int j = 0; j < c_P - 10; j++) begin
                if (bus.trig)        ntrig++;
                if (bus.width_valid) nv++;
                if (bus.timeout)     nt++;
                if ((bus.width_valid || bus.timeout) && first_off < 0) begin
                    first_off = j;
                    width_at  = int'(bus.echo_width);
                end
                if (j >= c_P - 20 && i < c_NVEC - 1) bus.echo = vecs[i + 1].stuck;
                else                                 bus.echo = echo_at(vecs[i], j);
                step();
            end
            check($sformatf("v%0d_trig_len", i),   ntrig,     c_TRIG);
            check($sformatf("v%0d_event_off", i),  first_off, vecs[i].exp_off);
            check($sformatf("v%0d_echo_width", i), width_at,  vecs[i].exp_width);
            check($sformatf("v%0d_valid_cnt", i),  nv,        vecs[i].exp_valid);
            check($sformatf("v%0d_timeout_cnt", i), nt,       vecs[i].exp_to);
        end

        if (!aborted) begin
            // en dropped mid-measurement: result still published, then park
            wait_trig(ok);
            if (ok) begin
                check("en_trig_period", edge_cnt - prev_rise, c_P);
                first_off = -1;
                width_at  = 0;
                nv = 0;
                nt = 0;
                ntrig = 0;
                for (int j = 0; j < 8000; j++) begin
                    if (bus.trig)        ntrig++;
                    if (bus.width_valid) nv++;
                    if (bus.timeout)     nt++;
                    if (bus.width_valid && first_off < 0) begin
                        first_off = j;
                        width_at  = int'(bus.echo_width);
                    end
                    if (j == 700) bus.en = 1'b0;
                    bus.echo = (j >= 500) && (j < 1500);
                    step();
                end
                check("en_off_event_off",   first_off, 1503);
                check("en_off_echo_width",  width_at,  1000);
                check("en_off_valid_cnt",   nv,        1);
                check("en_off_timeout_cnt", nt,        0);
                check("en_off_trig_cnt",    ntrig,     c_TRIG);
                check("en_off_held_width",  bus.echo_width, 1000);

                // Re-enable: trigger on the very next edge
                bus.en = 1'b1;
                step();
                check("en_on_trig_next", bus.trig, 1);
                step();
                step();
                check("mid_trig_high", bus.trig, 1);

                // Asynchronous reset in the middle of the trigger pulse
                #2 reset_n = 1'b0;
                #1;
                check("async_rst_trig",        bus.trig,        0);
                check("async_rst_echo_width",  bus.echo_width,  0);
                check("async_rst_width_valid", bus.width_valid, 0);
                check("async_rst_timeout",     bus.timeout,     0);
                repeat (2) step();
                reset_n = 1'b1;
                repeat (20) step();
                check("post_rst_trig",       bus.trig,       0);
                check("post_rst_echo_width", bus.echo_width, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ultrasonic_ranger
`default_nettype wire
